// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall vectors, exception codes
// and the controller state encoding.
package pipe_ctrl_pkg;

  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;
  localparam logic RstEnable = 1'b1;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Stall vectors, bit0 = pc ... bit5 = wb; each stops its stage and all older ones.
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam logic [31:0] EXC_INTERRUPT    = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID_INST = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW     = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Saturating count of consecutive stalled, unflushed cycles; raises a sticky
// flag once the count reaches STALL_TIMEOUT-1 while still stalled.
module pipe_ctrl_stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_pc_i,
  input  logic flush_i,
  output logic timeout_o
);

  localparam logic [15:0] LIMIT = 16'(STALL_TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        stalled;

  assign stalled = (stall_pc_i == Stop) && !flush_i;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (!stalled) begin
      cnt_d = 16'h0000;
    end else begin
      if (cnt_q != 16'hffff) cnt_d = cnt_q + 16'h0001;
      if (cnt_q >= LIMIT) timeout_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q     <= 16'h0000;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall encoder, exception/ERET flush sequencing and
// recovery window. Define PIPE_STALL_WATCHDOG_EN to build the stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned STALL_TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        in_recover,
  output logic        stall_timeout
);

  localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

  state_e     state_q;
  logic [3:0] rcnt_q;
  logic       rst_act;
  logic       idle;
  logic       exc_taken;

  assign rst_act   = (rst == RstEnable);
  assign idle      = (state_q == ST_IDLE);
  assign exc_taken = !rst_act && idle && (excepttype_i != ZeroWord);

  // In RECOVER the ID/EX requesters belong to squashed instructions.
  always_comb begin
    stall = STALL_NONE;
    if (rst_act || exc_taken)         stall = STALL_NONE;
    else if (stallreq_mem)            stall = STALL_MEM;
    else if (stallreq_ex && idle)     stall = STALL_EX;
    else if (stallreq_id && idle)     stall = STALL_ID;
    else if (stallreq_if)             stall = STALL_IF;
  end

  always_comb begin
    flush  = exc_taken;
    new_pc = ZeroWord;
    if (exc_taken) new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
  end

  always_ff @(posedge clk) begin
    if (rst_act) begin
      state_q <= ST_IDLE;
      rcnt_q  <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exc_taken) begin
            state_q <= ST_RECOVER;
            rcnt_q  <= RECOVER_LOAD;
          end
        end
        ST_RECOVER: begin
          if (rcnt_q == 4'd0) state_q <= ST_IDLE;
          else                rcnt_q  <= rcnt_q - 4'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_recover = (state_q == ST_RECOVER);

`ifdef PIPE_STALL_WATCHDOG_EN
  pipe_ctrl_stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_stall_watchdog (
    .clk       (clk),
    .rst       (rst),
    .stall_pc_i(stall[0]),
    .flush_i   (flush),
    .timeout_o (stall_timeout)
  );
`else
  assign stall_timeout = 1'b0 & (STALL_TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl; one table row per clock cycle,
// followed by a hand-written watchdog sequence.
module tb_pipe_ctrl;

`ifdef PIPE_STALL_WATCHDOG_EN
  localparam int unsigned TIMEOUT = 8;
  localparam logic WD = 1'b1;
`else
  localparam int unsigned TIMEOUT = 1024;
  localparam logic WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic [31:0] excepttype_i = '0;
  logic [31:0] cp0_epc_i = '0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        in_recover;
  logic        stall_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .EXC_VECTOR    (32'h0000_0020),
    .RECOVER_CYCLES(2),
    .STALL_TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .in_recover   (in_recover),
    .stall_timeout(stall_timeout)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;   // {mem, ex, id, if}
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_rec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] q, logic [31:0] x, logic [31:0] p,
                              logic [5:0] s, logic f, logic [31:0] npc, logic rc);
    vec_t v;
    v.rst = r; v.req = q; v.exc = x; v.epc = p;
    v.e_stall = s; v.e_flush = f; v.e_pc = npc; v.e_rec = rc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, sample mid-low phase, before the next rising edge.
  task automatic drive(input logic r, input logic [3:0] q, input logic [31:0] x, input logic [31:0] p);
    @(negedge clk);
    rst = r;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = q;
    excepttype_i = x;
    cp0_epc_i = p;
    #2;
  endtask

  initial begin
    //            rst  {m,e,i,f} exc          epc           stall      flush pc            rec
    vecs.push_back(mk(1, 4'b1000, 32'h8,       32'h0,        6'b000000, 0, 32'h0,        0));
    vecs.push_back(mk(1, 4'b0000, 32'h0,       32'h0,        6'b000000, 0, 32'h0,        0));
    vecs.push_back(mk(0, 4'b0010, 32'h0,       32'h0,        6'b000111, 0, 32'h0,        0));
    vecs.push_back(mk(0, 4'b1010, 32'h0,       32'h0,        6'b011111, 0, 32'h0,        0));
    vecs.push_back(mk(0, 4'b0100, 32'h0,       32'h0,        6'b001111, 0, 32'h0,        0));
    vecs.push_back(mk(0, 4'b0001, 32'h0,       32'h0,        6'b000011, 0, 32'h0,        0));
    vecs.push_back(mk(0, 4'b0000, 32'h0,       32'h0,        6'b000000, 0, 32'h0,        0));
    vecs.push_back(mk(0, 4'b0000, 32'h8,       32'h0,        6'b000000, 1, 32'h20,       0));
    vecs.push_back(mk(0, 4'b0000, 32'h0,       32'h0,        6'b000000, 0, 32'h0,        1));
    vecs.push_back(mk(0, 4'b0000, 32'h0,       32'h0,        6'b000000, 0, 32'h0,        1));
    vecs.push_back(mk(0, 4'b0000, 32'h0,       32'h0,        6'b000000, 0, 32'h0,        0));
    vecs.push_back(mk(0, 4'b0000, 32'he,       32'h00401234, 6'b000000, 1, 32'h00401234, 0));
    vecs.push_back(mk(0, 4'b0100, 32'hc,       32'h0,        6'b000000, 0, 32'h0,        1));
    vecs.push_back(mk(0, 4'b1000, 32'hc,       32'h0,        6'b011111, 0, 32'h0,        1));
    vecs.push_back(mk(0, 4'b0000, 32'h8,       32'h0,        6'b000000, 1, 32'h20,       0));
    vecs.push_back(mk(0, 4'b0010, 32'h0,       32'h0,        6'b000000, 0, 32'h0,        1));
    vecs.push_back(mk(0, 4'b0001, 32'h0,       32'h0,        6'b000011, 0, 32'h0,        1));
    vecs.push_back(mk(0, 4'b1000, 32'hd,       32'h0,        6'b000000, 1, 32'h20,       0));
    vecs.push_back(mk(0, 4'b0000, 32'h0,       32'h0,        6'b000000, 0, 32'h0,        1));
    vecs.push_back(mk(1, 4'b1000, 32'h8,       32'h0,        6'b000000, 0, 32'h0,        1));
    vecs.push_back(mk(0, 4'b0000, 32'h0,       32'h0,        6'b000000, 0, 32'h0,        0));
    vecs.push_back(mk(0, 4'b0001, 32'h1,       32'h0,        6'b000000, 1, 32'h20,       0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].exc, vecs[i].epc);
      check($sformatf("v%0d stall", i),      {26'd0, stall},       {26'd0, vecs[i].e_stall});
      check($sformatf("v%0d flush", i),      {31'd0, flush},       {31'd0, vecs[i].e_flush});
      check($sformatf("v%0d new_pc", i),     new_pc,               vecs[i].e_pc);
      check($sformatf("v%0d in_recover", i), {31'd0, in_recover},  {31'd0, vecs[i].e_rec});
      check($sformatf("v%0d timeout", i),    {31'd0, stall_timeout}, 32'd0);
    end

    // Watchdog: fresh reset, then hold the fetch stall.
    drive(1, 4'b0000, 32'h0, 32'h0);
    check("wd reset timeout", {31'd0, stall_timeout}, 32'd0);
    for (int c = 1; c <= 8; c++) begin
      drive(0, 4'b0001, 32'h0, 32'h0);
      check($sformatf("wd stalled cycle %0d", c), {31'd0, stall_timeout}, 32'd0);
    end
    drive(0, 4'b0001, 32'h0, 32'h0);
    check("wd after 8th stall", {31'd0, stall_timeout}, {31'd0, WD});
    drive(0, 4'b0000, 32'h0, 32'h0);
    check("wd sticky released", {31'd0, stall_timeout}, {31'd0, WD});
    drive(0, 4'b0000, 32'h8, 32'h0);
    check("wd sticky flush", {31'd0, stall_timeout}, {31'd0, WD});
    check("wd flush pc", new_pc, 32'h20);
    drive(1, 4'b0000, 32'h0, 32'h0);
    drive(0, 4'b0000, 32'h0, 32'h0);
    check("wd cleared by rst", {31'd0, stall_timeout}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
